// File: rtl/md_issue_ctrl.sv
// M-extension issue controller in front of multdiv: multiplies bypass with zero latency,
// divides are latched, started once the divider is idle, and stall the pipe until done/refresh.
package md_issue_pkg;
  typedef enum logic [3:0] {
    MD_MUL   = 4'd0,
    MD_MULH  = 4'd1,
    MD_MULSU = 4'd2,
    MD_MULU  = 4'd3,
    MD_DIV   = 4'd4,
    MD_DIVU  = 4'd5,
    MD_REM   = 4'd6,
    MD_REMU  = 4'd7
  } md_opt_e;
endpackage

module md_issue_ctrl
  import md_issue_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             md_valid_i,
  input  md_opt_e          md_operate_i,
  input  logic [31:0]      md_operand_a_i,
  input  logic [31:0]      md_operand_b_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rd_we_i,
  input  logic             refresh_pip_i,
  output logic             md_ready_o,
  output logic             stall_o,
  output logic             md_done_o,
  output md_opt_e          md_operate_o,
  output logic [31:0]      md_operand_a_o,
  output logic [31:0]      md_operand_b_o,
  output logic [4:0]       rd_addr_o,
  output logic             rd_we_o,
  output logic             div_start_o,
  input  logic             div_done_i,
  input  logic             div_busy_i,
  output logic [CNT_W-1:0] div_cycles_o,
  output logic             err_timeout_o
);

  localparam int WC_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(DIV_TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_LST = WC_W'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DIV_START, DIV_WAIT} state_e;

  state_e          state_q, state_d;
  md_opt_e         op_q;
  logic [31:0]     a_q, b_q;
  logic [4:0]      rd_q;
  logic            we_q;
  logic [WC_W-1:0] wait_q;
  logic [CNT_W-1:0] cyc_q;
  logic            err_q;

  logic [3:0] op_bits;
  logic       is_mul, is_div, accept_mul, accept_div;

  // Encodings 8..15 are illegal and fall into neither class.
  assign op_bits    = md_operate_i;
  assign is_mul     = (op_bits[3:2] == 2'b00);
  assign is_div     = (op_bits[3:2] == 2'b01);
  assign accept_mul = md_valid_i & is_mul & ~refresh_pip_i;
  assign accept_div = md_valid_i & is_div & ~refresh_pip_i;

  assign div_cycles_o  = cyc_q;
  assign err_timeout_o = err_q;

  always_comb begin
    state_d        = state_q;
    md_ready_o     = 1'b0;
    stall_o        = 1'b0;
    md_done_o      = 1'b0;
    rd_we_o        = 1'b0;
    div_start_o    = 1'b0;
    md_operate_o   = op_q;
    md_operand_a_o = a_q;
    md_operand_b_o = b_q;
    rd_addr_o      = rd_q;
    case (state_q)
      IDLE: begin
        md_ready_o     = ~refresh_pip_i;
        md_operate_o   = md_operate_i;
        md_operand_a_o = md_operand_a_i;
        md_operand_b_o = md_operand_b_i;
        rd_addr_o      = rd_addr_i;
        md_done_o      = accept_mul;
        rd_we_o        = accept_mul & rd_we_i;
        stall_o        = accept_div;
        if (accept_div) state_d = DIV_START;
      end
      DIV_START: begin
        stall_o     = 1'b1;
        div_start_o = ~div_busy_i & ~refresh_pip_i;
        if (refresh_pip_i)   state_d = IDLE;
        else if (!div_busy_i) state_d = DIV_WAIT;
      end
      DIV_WAIT: begin
        stall_o = ~div_done_i;
        // Refresh beats a coincident done: the result is dropped.
        if (refresh_pip_i) begin
          state_d = IDLE;
        end else if (div_done_i) begin
          md_done_o = 1'b1;
          rd_we_o   = we_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_ni) begin
      md_ready_o  = 1'b1;
      stall_o     = 1'b0;
      md_done_o   = 1'b0;
      rd_we_o     = 1'b0;
      div_start_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= MD_MUL;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept_div) begin
        op_q <= md_operate_i;
        a_q  <= md_operand_a_i;
        b_q  <= md_operand_b_i;
        rd_q <= rd_addr_i;
        we_q <= rd_we_i;
      end
      if (state_q != IDLE && cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
      // DIV_START always precedes DIV_WAIT, so clearing here clears on entry.
      if (state_q == DIV_START) begin
        wait_q <= '0;
      end else if (state_q == DIV_WAIT) begin
        if (wait_q != WAIT_MAX) wait_q <= wait_q + WC_W'(1);
        if (wait_q == WAIT_LST) err_q <= 1'b1;
      end
    end
  end

endmodule
